// File: rtl/soc_wb_sram_arbiter_if.sv
// soc_wb_sram_arbiter_if: Wishbone bus bundle between an initiator, the arbiter and the memory slave.
interface soc_wb_sram_arbiter_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack, err);
    modport slave (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack, err);
endinterface

// File: rtl/soc_wb_sram_arbiter.sv
// soc_wb_sram_arbiter: round-robin two-initiator Wishbone arbiter with a stall watchdog.
module soc_wb_sram_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_n_i,
    soc_wb_sram_arbiter_if.slave        m0,
    soc_wb_sram_arbiter_if.slave        m1,
    soc_wb_sram_arbiter_if.master       s,
    output logic [1:0]                  grant_o,
    output logic                        timeout_o
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TOERR} state_t;
    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);
    state_t     state;
    logic       last;
    logic [7:0] cnt;
    logic       granted;
    logic       own_cyc;
    logic       own_stb;
    logic       oth_cyc;
    logic       stalled;
    // outside IDLE, last always names the current owner
    assign granted = state == GRANT0 || state == GRANT1;
    assign own_cyc = last ? m1.cyc : m0.cyc;
    assign own_stb = last ? m1.stb : m0.stb;
    assign oth_cyc = last ? m0.cyc : m1.cyc;
    assign stalled = granted && own_stb && !s.ack && !s.err;
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            cnt <= stalled ? (cnt == 8'hff ? cnt : cnt + 8'd1) : '0;
            if (state == IDLE) begin
                if (m0.cyc && (!m1.cyc || last)) begin
                    state <= GRANT0;
                    last  <= 1'b0;
                end else if (m1.cyc) begin
                    state <= GRANT1;
                    last  <= 1'b1;
                end
            end else if (stalled && cnt == LIMIT) begin
                state <= TOERR;
            end else if (own_cyc) begin
                state <= last ? GRANT1 : GRANT0;
            end else if (oth_cyc) begin
                state <= last ? GRANT0 : GRANT1;
                last  <= !last;
            end else begin
                state <= IDLE;
            end
        end
    end
    assign s.cyc   = granted && own_cyc;
    assign s.stb   = granted && own_stb;
    assign s.we    = granted && (last ? m1.we : m0.we);
    assign s.adr   = last ? m1.adr : m0.adr;
    assign s.sel   = last ? m1.sel : m0.sel;
    assign s.dat_w = last ? m1.dat_w : m0.dat_w;
    // read data is broadcast; only the owner ever sees a termination
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;
    assign m0.ack   = granted && !last && s.ack;
    assign m1.ack   = granted && last && s.ack;
    assign m0.err   = !last && ((granted && s.err) || state == TOERR);
    assign m1.err   = last && ((granted && s.err) || state == TOERR);
    assign grant_o   = state == IDLE ? 2'b00 : last ? 2'b10 : 2'b01;
    assign timeout_o = state == TOERR;
endmodule
